// File: rtl/synth_pkg.sv
// Shared types and constants for the synth datapath.
//   wave_mode_t : waveform select carried to the waveshaper
//   seq_state_t : sample_sequencer FSM states
//   next_phase  : phase advance modulo fd, 17-bit safe
package synth_pkg;
  localparam int SAMPLE_W = 8;
  localparam int PHASE_W  = 16;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SAW    = 2'b11
  } wave_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } seq_state_t;

  // count+1 is formed in PHASE_W+1 bits so fd=65535 wraps to 0 correctly.
  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] cnt,
                                                     input logic [PHASE_W-1:0] fd);
    logic [PHASE_W:0] inc;
    inc = {1'b0, cnt} + (PHASE_W+1)'(1);
    if (fd == '0)               return '0;
    else if (inc >= {1'b0, fd}) return '0;
    else                        return inc[PHASE_W-1:0];
  endfunction
endpackage

// File: rtl/sample_sequencer_if.sv
// Start/done handshake between the sample sequencer (master) and the
// waveshaper (slave).
//   ws_start  : one-cycle request pulse
//   ws_fd     : latched note period for the request
//   ws_count  : latched phase for the request
//   ws_mode   : latched waveform select
//   ws_done   : one-cycle completion pulse
//   ws_signal : result, valid with ws_done
interface sample_sequencer_if;
  import synth_pkg::*;
  logic                 ws_start;
  logic [PHASE_W-1:0]   ws_fd;
  logic [PHASE_W-1:0]   ws_count;
  wave_mode_t           ws_mode;
  logic                 ws_done;
  logic [SAMPLE_W-1:0]  ws_signal;

  modport master (output ws_start, ws_fd, ws_count, ws_mode,
                  input  ws_done, ws_signal);
  modport slave  (input  ws_start, ws_fd, ws_count, ws_mode,
                  output ws_done, ws_signal);
endinterface

// File: rtl/sample_sequencer_tick_gen.sv
// Sample-rate tick generator.
//   clk, nrst : clock, async active-low reset
//   en        : run enable; low holds the counter at 0
//   tick      : high while the counter sits at SAMPLE_PERIOD-1
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            cnt <= '0;
    else if (!en)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/sample_sequencer.sv
// Initiator side of the waveshaper start/done handshake.
//   clk, nrst     : clock, async active-low reset
//   en            : run enable; low aborts, clears phase and sticky flags
//   fd_in         : note period in samples (0 = silence)
//   mode_in       : waveform select
//   ws            : handshake to the waveshaper (master side)
//   sample        : last captured waveshaper result
//   sample_valid  : one-cycle strobe for a new sample
//   busy          : request outstanding (REQ or WAIT)
//   overrun       : sticky, a tick arrived while busy
//   timeout       : sticky, the waveshaper failed to answer in time
module sample_sequencer
  import synth_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 200,
  parameter int TIMEOUT       = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic [PHASE_W-1:0]   fd_in,
  input  wave_mode_t           mode_in,
  sample_sequencer_if.master   ws,
  output logic [SAMPLE_W-1:0]  sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Counter reads 1 in the first WAIT cycle, so abandoning at TIMEOUT-1
  // returns to IDLE exactly TIMEOUT cycles after ws_start.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_t          state;
  logic [PHASE_W-1:0]  phase;
  logic [TW-1:0]       tmo_cnt;
  logic                tick;
  logic [PHASE_W-1:0]  clamp;

  sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .tick (tick)
  );

  // A shortened note can leave phase beyond the new period; restart at 0.
  assign clamp = (phase >= fd_in) ? '0 : phase;
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      phase        <= '0;
      tmo_cnt      <= '0;
      ws.ws_start  <= 1'b0;
      ws.ws_fd     <= '0;
      ws.ws_count  <= '0;
      ws.ws_mode   <= MODE_OFF;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      ws.ws_start  <= 1'b0;
      sample_valid <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        phase   <= '0;
        tmo_cnt <= '0;
        overrun <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (tick && state != ST_IDLE) overrun <= 1'b1;
        case (state)
          ST_IDLE: if (tick) begin
            ws.ws_fd    <= fd_in;
            ws.ws_mode  <= mode_in;
            ws.ws_count <= clamp;
            phase       <= clamp;
            ws.ws_start <= 1'b1;
            state       <= ST_REQ;
          end
          ST_REQ: begin
            tmo_cnt <= TW'(1);
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            if (ws.ws_done) begin
              sample       <= ws.ws_signal;
              sample_valid <= 1'b1;
              phase        <= next_phase(ws.ws_count, ws.ws_fd);
              state        <= ST_IDLE;
            end else if (tmo_cnt >= TMO_LAST) begin
              timeout <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
